// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, size codes and transfer-size helper for the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10,
        FAULT_ILLEGAL  = 2'b11
    } lsu_fault_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // Byte count of a transfer: 1, 2, 4 or 8
    function automatic logic [3:0] xfer_size(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_if
//  Description : Handshaked data-memory bus between the LSU and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if #(
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [3:0]        size;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, size, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, size, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_extend
//  Description : Combinational size/sign extender for right-justified load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] ext
);

    if (DATA_W == 64) begin : g_w64
        always_comb begin
            ext = raw;
            case (size)
                SIZE_B:  ext = {{(DATA_W-8){sign_ext & raw[7]}},   raw[7:0]};
                SIZE_H:  ext = {{(DATA_W-16){sign_ext & raw[15]}}, raw[15:0]};
                SIZE_W:  ext = {{(DATA_W-32){sign_ext & raw[31]}}, raw[31:0]};
                default: ext = raw;
            endcase
        end
    end else begin : g_w32
        always_comb begin
            ext = raw;
            case (size)
                SIZE_B:  ext = {{(DATA_W-8){sign_ext & raw[7]}},   raw[7:0]};
                SIZE_H:  ext = {{(DATA_W-16){sign_ext & raw[15]}}, raw[15:0]};
                default: ext = raw;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store unit FSM: address generation, alignment check,
//                handshaked memory transaction with ack timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int OFF_W   = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] base,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fault,
    output logic [DATA_W-1:0] load_data,
    lsu_if.master             mem
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t        state, state_nxt;
    logic [DATA_W-1:0] ea, ea_q, wdata_q, wmask, ext_data;
    logic [3:0]        align_mask, bytes_q;
    logic [1:0]        size_q;
    logic              is_load_q, sign_q;
    logic [CNT_W-1:0]  cnt;
    logic              illegal, misaligned;
    logic              fault_we, load_we;
    lsu_fault_t        fault_nxt;

    assign ea         = base + {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign illegal    = (DATA_W == 32) && (size == SIZE_D);
    assign align_mask = xfer_size(size) - 4'd1;
    assign misaligned = |(ea[3:0] & align_mask);

    always_comb begin
        wmask = '1;
        case (size)
            SIZE_B:  wmask = DATA_W'(8'hFF);
            SIZE_H:  wmask = DATA_W'(16'hFFFF);
            SIZE_W:  wmask = DATA_W'(32'hFFFF_FFFF);
            default: wmask = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fault_we  = 1'b0;
        fault_nxt = FAULT_OK;
        load_we   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (illegal) begin
                        state_nxt = DONE;
                        fault_we  = 1'b1;
                        fault_nxt = FAULT_ILLEGAL;
                    end else if (misaligned) begin
                        state_nxt = DONE;
                        fault_we  = 1'b1;
                        fault_nxt = FAULT_MISALIGN;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                // Ack wins over a timeout landing in the same cycle
                if (mem.ack) begin
                    state_nxt = DONE;
                    fault_we  = 1'b1;
                    fault_nxt = FAULT_OK;
                    load_we   = is_load_q;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    fault_we  = 1'b1;
                    fault_nxt = FAULT_TIMEOUT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ea_q      <= '0;
            wdata_q   <= '0;
            bytes_q   <= '0;
            size_q    <= '0;
            is_load_q <= 1'b0;
            sign_q    <= 1'b0;
            cnt       <= '0;
            fault     <= FAULT_OK;
            load_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                ea_q      <= ea;
                wdata_q   <= store_data & wmask;
                bytes_q   <= xfer_size(size);
                size_q    <= size;
                is_load_q <= is_load;
                sign_q    <= sign_ext;
                cnt       <= '0;
            end else if (state == REQ) begin
                cnt <= cnt + 1'b1;
            end
            if (fault_we) fault     <= fault_nxt;
            if (load_we)  load_data <= ext_data;
        end
    end

    lsu_extend #(.DATA_W(DATA_W)) u_extend (
        .raw      (mem.rdata),
        .size     (size_q),
        .sign_ext (sign_q),
        .ext      (ext_data)
    );

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem.req   = (state == REQ);
    assign mem.we    = (state == REQ) && !is_load_q;
    assign mem.addr  = ea_q;
    assign mem.size  = bytes_q;
    assign mem.wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Directed self-checking bench for lsu_ctrl (DATA_W=64, TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [63:0] base = '0;
    logic [8:0]  offset = '0;
    logic [63:0] store_data = '0;
    logic        busy, done;
    logic [1:0]  fault;
    logic [63:0] load_data;

    int total = 0;
    int bad   = 0;

    lsu_if #(.DATA_W(64)) mem_bus ();

    lsu_ctrl #(.DATA_W(64), .OFF_W(9), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_load    (is_load),
        .size       (size),
        .sign_ext   (sign_ext),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one sampling edge; returns just after that edge
    task automatic start_op(input logic ld, input logic [1:0] sz, input logic sx,
                            input logic [63:0] b, input logic [8:0] off, input logic [63:0] sd);
        is_load    = ld;
        size       = sz;
        sign_ext   = sx;
        base       = b;
        offset     = off;
        store_data = sd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = '0;
        tick();
        tick();
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_fault", fault, 0);
        check("rst_ldata", load_data, 0);
        check("rst_req",   mem_bus.req, 0);
        check("rst_we",    mem_bus.we, 0);
        check("rst_addr",  mem_bus.addr, 0);
        check("rst_size",  mem_bus.size, 0);
        check("rst_wdata", mem_bus.wdata, 0);
        reset = 1'b0;

        // Ack while idle must be ignored
        mem_bus.ack = 1'b1;
        tick();
        check("idle_ack_busy", busy, 0);
        mem_bus.ack = 1'b0;

        // Load byte, sign-extend, ack on first REQ cycle
        start_op(1'b1, 2'b00, 1'b1, 64'h100, 9'h1FF, 64'h0);
        check("lb_req",  mem_bus.req, 1);
        check("lb_addr", mem_bus.addr, 64'hFF);
        check("lb_size", mem_bus.size, 1);
        check("lb_we",   mem_bus.we, 0);
        check("lb_busy", busy, 1);
        check("lb_nodone", done, 0);
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 64'h80;
        tick();
        mem_bus.ack = 1'b0;
        check("lb_done",  done, 1);
        check("lb_fault", fault, 0);
        check("lb_ldata", load_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_busy_done", busy, 1);
        check("lb_req_off", mem_bus.req, 0);
        tick();
        check("lb_done_off", done, 0);
        check("lb_idle", busy, 0);

        // Load half, zero-extend, ack in the 4th REQ cycle (== TIMEOUT)
        start_op(1'b1, 2'b01, 1'b0, 64'h200, 9'd2, 64'h0);
        for (int i = 1; i <= 3; i++) begin
            check("lh_req_hold", mem_bus.req, 1);
            check("lh_busy", busy, 1);
            check("lh_nodone", done, 0);
            tick();
        end
        check("lh_req4",  mem_bus.req, 1);
        check("lh_addr",  mem_bus.addr, 64'h202);
        check("lh_size",  mem_bus.size, 2);
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 64'hABCD_8001;
        tick();
        mem_bus.ack = 1'b0;
        check("lh_done",  done, 1);
        check("lh_fault", fault, 0);
        check("lh_ldata", load_data, 64'h8001);
        tick();

        // Store double
        start_op(1'b0, 2'b11, 1'b0, 64'h1000, 9'd8, 64'h1122_3344_5566_7788);
        check("sd_we",    mem_bus.we, 1);
        check("sd_size",  mem_bus.size, 8);
        check("sd_addr",  mem_bus.addr, 64'h1008);
        check("sd_wdata", mem_bus.wdata, 64'h1122_3344_5566_7788);
        mem_bus.ack = 1'b1;
        tick();
        mem_bus.ack = 1'b0;
        check("sd_done",  done, 1);
        check("sd_fault", fault, 0);
        check("sd_ldata", load_data, 64'h8001);
        tick();

        // Store byte: upper store bits are zeroed on the bus
        start_op(1'b0, 2'b00, 1'b0, 64'h1003, 9'd0, 64'hDEAD_BEEF_CAFE_F0AB);
        check("sb_wdata", mem_bus.wdata, 64'hAB);
        check("sb_size",  mem_bus.size, 1);
        mem_bus.ack = 1'b1;
        tick();
        mem_bus.ack = 1'b0;
        check("sb_done", done, 1);
        tick();

        // Misaligned word load: fault path, no memory request
        start_op(1'b1, 2'b10, 1'b0, 64'h102, 9'd0, 64'h0);
        check("mis_req",   mem_bus.req, 0);
        check("mis_done",  done, 1);
        check("mis_fault", fault, 2'b01);
        check("mis_ldata", load_data, 64'h8001);
        tick();
        check("mis_done_off", done, 0);
        check("mis_req_off",  mem_bus.req, 0);

        // Timeout with no ack; a start mid-REQ must not be queued
        start_op(1'b1, 2'b10, 1'b0, 64'h300, 9'd0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("to_req_hold", mem_bus.req, 1);
            check("to_nodone", done, 0);
            start = (i == 1);
            tick();
        end
        start = 1'b0;
        check("to_req_drop", mem_bus.req, 0);
        check("to_done",  done, 1);
        check("to_fault", fault, 2'b10);
        check("to_ldata", load_data, 64'h8001);
        tick();
        check("to_done_off", done, 0);
        check("to_idle", busy, 0);
        tick();
        check("to_single_done", done, 0);
        check("to_no_queue", busy, 0);

        // Load word, sign-extend; fault clears back to ok
        start_op(1'b1, 2'b10, 1'b1, 64'h400, 9'h1FC, 64'h0);
        check("lw_addr", mem_bus.addr, 64'h3FC);
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 64'h1234_5678_8000_0001;
        tick();
        mem_bus.ack = 1'b0;
        check("lw_done",  done, 1);
        check("lw_fault", fault, 0);
        check("lw_ldata", load_data, 64'hFFFF_FFFF_8000_0001);
        tick();

        // Reset in the second REQ cycle
        start_op(1'b1, 2'b00, 1'b0, 64'h40, 9'd0, 64'h0);
        tick();
        check("rr_req2", mem_bus.req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_req",   mem_bus.req, 0);
        check("rr_busy",  busy, 0);
        check("rr_done",  done, 0);
        check("rr_ldata", load_data, 0);
        tick();
        check("rr_nodone", done, 0);
        start_op(1'b1, 2'b00, 1'b0, 64'h41, 9'd0, 64'h0);
        check("rr2_req",  mem_bus.req, 1);
        check("rr2_addr", mem_bus.addr, 64'h41);
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 64'hF0;
        tick();
        mem_bus.ack = 1'b0;
        check("rr2_done",  done, 1);
        check("rr2_ldata", load_data, 64'hF0);
        tick();
        check("rr2_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
